// File: rtl/conv_window_sequencer_pkg.sv
// Shared types and derived-dimension helpers for the convolution window sequencer.
package conv_window_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Output map extent along one axis for a valid (unpadded) convolution.
  function automatic int out_dim(input int map_dim, input int k);
    return map_dim - k + 1;
  endfunction

  function automatic int tap_count(input int k);
    return k * k;
  endfunction

endpackage

// File: rtl/conv_tag_delay.sv
// RD_LAT-deep shift register aligning read tags with RAM read data; MSB of the tag is its valid bit.
module conv_tag_delay #(
  parameter int RD_LAT = 1,
  parameter int W      = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] tag_in,
  output logic [W-1:0] tag_out,
  output logic         inflight
);

  logic [W-1:0] stage_q [RD_LAT];
  logic [W-1:0] stage_d [RD_LAT];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < RD_LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_out = stage_q[RD_LAT-1];

  // Reads still in flight after the coming shift; the output stage is leaving.
  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      inflight = inflight | stage_q[i][W-1];
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Sequences port-A reads of a KxK sliding window over the input map and tags them for the MAC.
// Optional CONV_SEQ_PERF_EN adds a saturating stall_cycles counter output.
module conv_window_sequencer
  import conv_window_sequencer_pkg::*;
#(
  parameter int IN_FEATURE_ADDR_WIDTH = 11,
  parameter int MAP_W  = 32,
  parameter int MAP_H  = 32,
  parameter int K      = 5,
  parameter int RD_LAT = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             start,
  input  logic                             stall,
  input  logic [IN_FEATURE_ADDR_WIDTH-1:0] cfg_base,
  output logic                             in_feature_rden_a,
  output logic [IN_FEATURE_ADDR_WIDTH-1:0] in_feature_addr_a,
  output logic                             mac_valid,
  output logic                             mac_first,
  output logic                             mac_last,
  output logic [IN_FEATURE_ADDR_WIDTH-1:0] out_pix_idx,
  output logic                             busy,
  output logic                             done
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0]                      stall_cycles
`endif
);

  localparam int AW    = IN_FEATURE_ADDR_WIDTH;
  localparam int OUT_W = out_dim(MAP_W, K);
  localparam int OUT_H = out_dim(MAP_H, K);
  localparam int CW    = $clog2((MAP_W > MAP_H) ? MAP_W : MAP_H) + 1;
  localparam int TW    = AW + 3;
  localparam logic [CW-1:0] KM1 = CW'(K - 1);
  localparam logic [CW-1:0] OXM = CW'(OUT_W - 1);
  localparam logic [CW-1:0] OYM = CW'(OUT_H - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
  logic [AW-1:0] base_q, base_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic          issue, accept, last_tap, inflight;
  logic [AW-1:0] rd_addr, pix;
  logic [TW-1:0] tag_in, tag_out;

  always_comb begin
    state_d = state_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    base_d  = base_q;
    issue   = (state_q == ST_RUN) && enable && !stall;
    accept  = (state_q == ST_IDLE) && start && enable;
    last_tap = (kx_q == KM1) && (ky_q == KM1) && (ox_q == OXM) && (oy_q == OYM);

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          kx_d    = '0;
          ky_d    = '0;
          ox_d    = '0;
          oy_d    = '0;
          base_d  = cfg_base;
        end
      end
      ST_RUN: begin
        if (issue) begin
          // kx innermost, then ky, then ox, then oy
          if (kx_q != KM1) begin
            kx_d = kx_q + ONE;
          end else begin
            kx_d = '0;
            if (ky_q != KM1) begin
              ky_d = ky_q + ONE;
            end else begin
              ky_d = '0;
              if (ox_q != OXM) begin
                ox_d = ox_q + ONE;
              end else begin
                ox_d = '0;
                oy_d = (oy_q != OYM) ? oy_q + ONE : '0;
              end
            end
          end
          if (last_tap) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      kx_q    <= '0;
      ky_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      base_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      base_q  <= base_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Address wraps modulo the RAM size by truncation.
  always_comb begin
    rd_addr = base_q + AW'(32'(oy_q + ky_q) * MAP_W + 32'(ox_q + kx_q));
    pix     = AW'(32'(oy_q) * OUT_W + 32'(ox_q));
    tag_in  = issue ? {1'b1, (kx_q == '0) && (ky_q == '0), (kx_q == KM1) && (ky_q == KM1), pix}
                    : '0;
  end

  conv_tag_delay #(
    .RD_LAT (RD_LAT),
    .W      (TW)
  ) u_tag_delay (
    .clock    (clock),
    .reset    (reset),
    .tag_in   (tag_in),
    .tag_out  (tag_out),
    .inflight (inflight)
  );

  assign in_feature_rden_a = issue;
  assign in_feature_addr_a = (state_q == ST_RUN) ? rd_addr : '0;
  assign {mac_valid, mac_first, mac_last, out_pix_idx} = tag_out;
  assign busy = busy_q;
  assign done = done_q;

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (accept) begin
      stall_cnt_d = '0;
    end else if ((state_q == ST_RUN) && !issue && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer on a 4x4 map, K=3, single-cycle RAM latency.
module tb_conv_window_sequencer;

  localparam int AW     = 11;
  localparam int MW     = 4;
  localparam int MH     = 4;
  localparam int KK     = 3;
  localparam int LAT    = 1;
  localparam int OW     = MW - KK + 1;
  localparam int OH     = MH - KK + 1;
  localparam int NREADS = OW * OH * KK * KK;
  localparam int VW     = 2 * AW + 6;

  typedef struct packed {
    logic          v;
    logic          f;
    logic          l;
    logic [AW-1:0] pix;
  } tag_t;

  logic          clock, reset, enable, start, stall;
  logic [AW-1:0] cfg_base;
  logic          rden, mac_valid, mac_first, mac_last, busy, done;
  logic [AW-1:0] addr, out_pix_idx;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  conv_window_sequencer #(
    .IN_FEATURE_ADDR_WIDTH (AW),
    .MAP_W  (MW),
    .MAP_H  (MH),
    .K      (KK),
    .RD_LAT (LAT)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .start             (start),
    .stall             (stall),
    .cfg_base          (cfg_base),
    .in_feature_rden_a (rden),
    .in_feature_addr_a (addr),
    .mac_valid         (mac_valid),
    .mac_first         (mac_first),
    .mac_last          (mac_last),
    .out_pix_idx       (out_pix_idx),
    .busy              (busy),
    .done              (done)
`ifdef CONV_SEQ_PERF_EN
    ,
    .stall_cycles      (stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  // Reference: expected read list built from the address formula, plus a latency line.
  logic [AW-1:0] r_addr [NREADS];
  tag_t          r_tag  [NREADS];
  bit            m_active;
  int            m_tail, m_next;
  tag_t          m_pipe [LAT];
  longint        m_perf;
  bit            e_issue;
  logic [VW-1:0] exp_v, obs_v;

  // Per-pass observations for the directed checks.
  int            cyc, cur_cyc, n_rden, n_valid, n_done, n_busy;
  int            first_rd_cyc, last_rd_cyc, first_val_cyc, last_val_cyc, done_cyc;
  logic [AW-1:0] rd_log [9];
  logic [AW-1:0] last_rd_addr;
  logic [AW-1:0] pix_log [$];
  int            exp_win [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

  task automatic build_reads(input int base);
    int n = 0;
    for (int oy = 0; oy < OH; oy++)
      for (int ox = 0; ox < OW; ox++)
        for (int ky = 0; ky < KK; ky++)
          for (int kx = 0; kx < KK; kx++) begin
            r_addr[n]    = AW'(base + (oy + ky) * MW + ox + kx);
            r_tag[n].v   = 1'b1;
            r_tag[n].f   = (kx == 0) && (ky == 0);
            r_tag[n].l   = (kx == KK - 1) && (ky == KK - 1);
            r_tag[n].pix = AW'(oy * OW + ox);
            n++;
          end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_tail   = 0;
    m_next   = 0;
    m_perf   = 0;
    for (int i = 0; i < LAT; i++) m_pipe[i] = '0;
  endtask

  task automatic clear_stats();
    cyc = 0; n_rden = 0; n_valid = 0; n_done = 0; n_busy = 0;
    first_rd_cyc = -1; last_rd_cyc = -1; first_val_cyc = -1; last_val_cyc = -1; done_cyc = -1;
    last_rd_addr = '0;
    for (int i = 0; i < 9; i++) rd_log[i] = '0;
    pix_log.delete();
  endtask

  // Drives one cycle's inputs, forms expected/observed vectors and logs observations.
  task automatic drive_cycle(input logic st, input logic en, input logic sl);
    int ix;
    @(negedge clock);
    start = st; enable = en; stall = sl;
    #1;
    ix      = (m_next < NREADS) ? m_next : 0;
    e_issue = m_active && en && !sl;
    exp_v = {e_issue, (m_active ? r_addr[ix] : AW'(0)), m_pipe[LAT-1],
             (m_active || m_tail != 0), (m_tail == LAT + 1)};
    obs_v = {rden, addr, mac_valid, mac_first, mac_last, out_pix_idx, busy, done};
    cur_cyc = cyc;
    if (rden) begin
      if (n_rden < 9) rd_log[n_rden] = addr;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      last_rd_cyc  = cyc;
      last_rd_addr = addr;
      n_rden++;
    end
    if (mac_valid) begin
      if (first_val_cyc < 0) first_val_cyc = cyc;
      last_val_cyc = cyc;
      n_valid++;
    end
    if (mac_last) pix_log.push_back(out_pix_idx);
    if (done) begin done_cyc = cyc; n_done++; end
    if (busy) n_busy++;
    cyc++;
  endtask

  task automatic model_advance(input logic st, input logic en);
    tag_t nt;
    bit   was_idle;
    nt       = e_issue ? r_tag[m_next] : '0;
    was_idle = !m_active && (m_tail == 0);
    if (m_active && !e_issue && m_perf != 64'hFFFF_FFFF) m_perf++;
    for (int i = LAT - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = nt;
    if (e_issue) begin
      m_next++;
      if (m_next == NREADS) begin m_active = 0; m_tail = 1; end
    end else if (m_tail != 0) begin
      m_tail = (m_tail == LAT + 1) ? 0 : m_tail + 1;
    end
    if (was_idle && st && en) begin
      build_reads(int'(cfg_base));
      m_active = 1;
      m_next   = 0;
      m_perf   = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; start = 1'b0; stall = 1'b0; cfg_base = '0;
    model_reset();
    #2;
    obs_v = {rden, addr, mac_valid, mac_first, mac_last, out_pix_idx, busy, done};
    checks++;
    if (obs_v !== '0) begin fails++; $display("FAIL reset_outputs got=%h exp=0", obs_v); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cur_cyc, obs_v, exp_v); end
      model_advance(1'b0, 1'b1);
    end
  endtask

  task automatic test_basic();
    cfg_base = '0;
    clear_stats();
    for (int c = 0; c < 45; c++) begin
      drive_cycle(c == 0, 1'b1, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL basic_cycle cyc=%0d got=%h exp=%h", cur_cyc, obs_v, exp_v); end
      model_advance(c == 0, 1'b1);
    end
    checks++; if (first_rd_cyc != 1 || last_rd_cyc != 36) begin fails++; $display("FAIL basic_rden_span got=%0d..%0d exp=1..36", first_rd_cyc, last_rd_cyc); end
    checks++; if (n_rden != 36) begin fails++; $display("FAIL basic_read_count got=%0d exp=36", n_rden); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (rd_log[i] !== AW'(exp_win[i])) begin fails++; $display("FAIL basic_window_addr tap=%0d got=%0d exp=%0d", i, rd_log[i], exp_win[i]); end
    end
    checks++; if (last_rd_addr !== AW'(15)) begin fails++; $display("FAIL basic_last_addr got=%0d exp=15", last_rd_addr); end
    checks++; if (first_val_cyc != 2 || last_val_cyc != 37) begin fails++; $display("FAIL basic_valid_span got=%0d..%0d exp=2..37", first_val_cyc, last_val_cyc); end
    checks++; if (pix_log.size() != 4) begin fails++; $display("FAIL basic_last_count got=%0d exp=4", pix_log.size()); end
    for (int i = 0; i < pix_log.size() && i < 4; i++) begin
      checks++;
      if (pix_log[i] !== AW'(i)) begin fails++; $display("FAIL basic_pix_idx n=%0d got=%0d exp=%0d", i, pix_log[i], i); end
    end
    checks++; if (done_cyc != 38 || n_done != 1) begin fails++; $display("FAIL basic_done got_cyc=%0d n=%0d exp_cyc=38 n=1", done_cyc, n_done); end
  endtask

  task automatic test_stall();
    cfg_base = '0;
    clear_stats();
    for (int c = 0; c < 48; c++) begin
      drive_cycle(c == 0, 1'b1, (c >= 5 && c <= 7));
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL stall_cycle cyc=%0d got=%h exp=%h", cur_cyc, obs_v, exp_v); end
      model_advance(c == 0, 1'b1);
    end
    checks++; if (n_rden != 36 || n_valid != 36) begin fails++; $display("FAIL stall_counts got_rd=%0d got_val=%0d exp=36", n_rden, n_valid); end
    checks++; if (done_cyc != 41) begin fails++; $display("FAIL stall_done got=%0d exp=41", done_cyc); end
`ifdef CONV_SEQ_PERF_EN
    checks++; if (stall_cycles !== 32'd3) begin fails++; $display("FAIL stall_perf got=%0d exp=3", stall_cycles); end
`endif
  endtask

  task automatic test_wrap();
    cfg_base = AW'(2046);
    clear_stats();
    for (int c = 0; c < 45; c++) begin
      drive_cycle(c == 0, 1'b1, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL wrap_cycle cyc=%0d got=%h exp=%h", cur_cyc, obs_v, exp_v); end
      model_advance(c == 0, 1'b1);
    end
    checks++; if (rd_log[0] !== AW'(2046)) begin fails++; $display("FAIL wrap_first got=%0d exp=2046", rd_log[0]); end
    checks++; if (rd_log[2] !== AW'(0)) begin fails++; $display("FAIL wrap_third got=%0d exp=0", rd_log[2]); end
    checks++; if (last_rd_addr !== AW'(13)) begin fails++; $display("FAIL wrap_last got=%0d exp=13", last_rd_addr); end
  endtask

  task automatic test_second_start();
    cfg_base = '0;
    clear_stats();
    for (int c = 0; c < 45; c++) begin
      drive_cycle(c == 0 || c == 10, 1'b1, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL restart_cycle cyc=%0d got=%h exp=%h", cur_cyc, obs_v, exp_v); end
      model_advance(c == 0 || c == 10, 1'b1);
    end
    checks++; if (n_rden != 36 || done_cyc != 38) begin fails++; $display("FAIL restart_ignored got_rd=%0d got_done=%0d exp=36,38", n_rden, done_cyc); end
  endtask

  task automatic test_reset_mid();
    cfg_base = '0;
    clear_stats();
    for (int c = 0; c < 20; c++) begin
      drive_cycle(c == 0, 1'b1, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL rstmid_cycle cyc=%0d got=%h exp=%h", cur_cyc, obs_v, exp_v); end
      model_advance(c == 0, 1'b1);
    end
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    model_reset();
    obs_v = {rden, addr, mac_valid, mac_first, mac_last, out_pix_idx, busy, done};
    checks++;
    if (obs_v !== '0) begin fails++; $display("FAIL rstmid_async got=%h exp=0", obs_v); end
`ifdef CONV_SEQ_PERF_EN
    checks++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL rstmid_perf got=%0d exp=0", stall_cycles); end
`endif
    repeat (2) @(negedge clock);
    reset = 1'b0;
    clear_stats();
    for (int c = 0; c < 10; c++) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL rstmid_quiet cyc=%0d got=%h exp=%h", cur_cyc, obs_v, exp_v); end
      model_advance(1'b0, 1'b1);
    end
    checks++; if (n_done != 0 || n_busy != 0) begin fails++; $display("FAIL rstmid_no_done got_done=%0d got_busy=%0d exp=0", n_done, n_busy); end
    clear_stats();
    for (int c = 0; c < 45; c++) begin
      drive_cycle(c == 0, 1'b1, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL rstmid_rerun cyc=%0d got=%h exp=%h", cur_cyc, obs_v, exp_v); end
      model_advance(c == 0, 1'b1);
    end
    checks++; if (n_rden != 36 || done_cyc != 38) begin fails++; $display("FAIL rstmid_full_pass got_rd=%0d got_done=%0d exp=36,38", n_rden, done_cyc); end
  endtask

  task automatic test_enable_gate();
    cfg_base = AW'(100);
    clear_stats();
    for (int c = 0; c < 10; c++) begin
      drive_cycle(c == 2, 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL engate_cycle cyc=%0d got=%h exp=%h", cur_cyc, obs_v, exp_v); end
      model_advance(c == 2, 1'b0);
    end
    checks++; if (n_busy != 0 || n_rden != 0) begin fails++; $display("FAIL engate_ignored got_busy=%0d got_rd=%0d exp=0", n_busy, n_rden); end
    clear_stats();
    for (int c = 0; c < 45; c++) begin
      drive_cycle(c == 0, 1'b1, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL engate_run cyc=%0d got=%h exp=%h", cur_cyc, obs_v, exp_v); end
      model_advance(c == 0, 1'b1);
    end
    checks++; if (n_rden != 36 || done_cyc != 38 || rd_log[0] !== AW'(100)) begin
      fails++; $display("FAIL engate_accepted got_rd=%0d got_done=%0d got_addr0=%0d exp=36,38,100", n_rden, done_cyc, rd_log[0]);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 6; p++) begin
      int   c;
      logic st, en, sl;
      cfg_base = AW'($urandom_range(0, 2047));
      clear_stats();
      c = 0;
      do begin
        st = (c == 0) || ($urandom_range(0, 15) == 0);
        en = (c == 0) || ($urandom_range(0, 5) != 0);
        sl = (c != 0) && ($urandom_range(0, 3) == 0);
        drive_cycle(st, en, sl);
        checks++;
        if (obs_v !== exp_v) begin fails++; $display("FAIL random_cycle pass=%0d cyc=%0d got=%h exp=%h", p, cur_cyc, obs_v, exp_v); end
        model_advance(st, en);
        c++;
      end while ((m_active || m_tail != 0) && c < 600);
      checks++;
      if (m_active || m_tail != 0) begin fails++; $display("FAIL random_timeout pass=%0d cycles=%0d", p, c); end
`ifdef CONV_SEQ_PERF_EN
      @(negedge clock);
      checks++;
      if (stall_cycles !== 32'(m_perf)) begin fails++; $display("FAIL random_perf pass=%0d got=%0d exp=%0d", p, stall_cycles, m_perf); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_second_start();
    test_reset_mid();
    test_enable_gate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
Scheduler sitting between the cnp top-level enable/start logic and the input-feature dual-port RAM. Sequences port-A reads of a K x K sliding window over an MAP_H x MAP_W input feature map and emits tagged valid/first/last strobes aligned to RAM read data for the MAC datapath. Port B is left free for the feature loader. Signals when a full output map has been scheduled.

Parameters:
IN_FEATURE_ADDR_WIDTH, 11, RAM address width
MAP_W, 32, input map width (pixels)
MAP_H, 32, input map height (pixels)
K, 5, square kernel size; requires K<=MAP_W and K<=MAP_H
RD_LAT, 1, RAM read latency in cycles (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  global run enable; low freezes issue
start  in  1  one-cycle pulse; begins a map pass from IDLE
stall  in  1  downstream back-pressure; high freezes issue
cfg_base  in  IN_FEATURE_ADDR_WIDTH  base address of map in RAM, sampled on accepted start
in_feature_rden_a  out  1  port-A read enable
in_feature_addr_a  out  IN_FEATURE_ADDR_WIDTH  port-A read address
mac_valid  out  1  RAM data valid for MAC this cycle
mac_first  out  1  first tap of a window (clear accumulator)
mac_last  out  1  last tap of a window (accumulator result ready)
out_pix_idx  out  IN_FEATURE_ADDR_WIDTH  linear output-pixel index, valid with mac_last
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse, pass complete

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; counters and tag pipeline cleared. Reset mid-pass aborts with no done.
- Counters: ox 0..MAP_W-K, oy 0..MAP_H-K, kx 0..K-1, ky 0..K-1; kx innermost, then ky, then ox, then oy.
- Address = cfg_base + (oy+ky)*MAP_W + (ox+kx), truncated mod 2^IN_FEATURE_ADDR_WIDTH (wraps silently).
- FSM: IDLE -> RUN on start while enable=1 (registered; first read issued the next cycle). RUN -> DRAIN after last tap issued. DRAIN -> DONE when the tag pipeline is empty. DONE -> IDLE after one cycle; done=1 in DONE only.
- start while not IDLE: ignored. start with enable=0: ignored.
- RUN: in_feature_rden_a=1 and counters advance in any cycle where enable=1 and stall=0; otherwise rden=0, address holds, counters hold.
- Tag pipeline: RD_LAT-deep shift of {issued, first, last, pix_idx}. mac_valid/first/last/out_pix_idx equal the tags issued RD_LAT cycles earlier; always shifts (in-flight reads complete regardless of stall/enable).
- mac_first when kx=ky=0; mac_last when kx=ky=K-1. out_pix_idx = oy*(MAP_W-K+1)+ox.
- busy=1 in RUN, DRAIN, DONE.
- Total reads per pass = (MAP_W-K+1)*(MAP_H-K+1)*K*K.

Optional Feature:
CONV_SEQ_PERF_EN: adds output stall_cycles (32 bits). It counts RUN cycles with issue blocked (stall=1 or enable=0), clears on accepted start, saturates at all-ones, and holds after done. Without the macro, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package: FSM state encoding (IDLE, RUN, DRAIN, DONE); derived constants OUT_W=MAP_W-K+1, OUT_H=MAP_H-K+1, TAPS=K*K.
- One sub-module, conv_tag_delay: parameterised RD_LAT shift register for the tag bundle, with async reset.

Test Plan:
- MAP_W=4, MAP_H=4, K=3, cfg_base=0, start at cycle 0 → rden cycles 1-36; first-window addresses 0,1,2,4,5,6,8,9,10; last address 15; mac_valid cycles 2-37; 4 mac_last pulses with out_pix_idx 0,1,2,3; done at cycle 38.
- Same config, stall=1 for cycles 5-7 → rden low and address held for 3 cycles; in-flight mac_valid still delivered; done at cycle 41; stall_cycles=3 when CONV_SEQ_PERF_EN is defined.
- cfg_base=2046, 4x4, K=3 → first address 2046, third tap 0 (wrap); last address 13.
- Second start pulse at cycle 10 during RUN → ignored; sequence identical to the first test.
- reset asserted at cycle 20 → all outputs 0 immediately (async); no done; new start accepted after reset release with a full 36-read pass.
- enable=0 with a start pulse → stays IDLE, busy=0; with enable=1, a later start is accepted.
